siso_ring_sequencer: RTL and testbench
======================================

SISO_RING_SEQUENCER -- requirements
Module: siso_ring_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the ring register width in bits (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the rotate step-count width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  opcode: 00 LOAD, 01 ROT_LEFT, 10 ROT_RIGHT, 11 CLEAR.
REQ-008 SHALL have port cmd_pat  input  WIDTH  pattern for LOAD; ignored otherwise.
REQ-009 SHALL have port cmd_cnt  input  CNT_W  step count for ROT_*; ignored otherwise.
REQ-010 SHALL have port hold  input  1  freeze rotation while high.
REQ-011 SHALL have port q  output  WIDTH  ring register contents.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking command completion.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 cmd_ready SHALL be high only in IDLE, combinationally from state; a command is accepted on the edge where cmd_valid and cmd_ready are both high.
REQ-016 LOAD accepted: q SHALL equal cmd_pat after the accepting edge; state -> DONE.
REQ-017 CLEAR accepted: q SHALL be all zeros after the accepting edge; state -> DONE.
REQ-018 ROT_* with cmd_cnt = 0: q unchanged; state -> DONE.
REQ-019 ROT_* with cmd_cnt = n > 0: direction and n SHALL be latched; state -> SHIFT; q unchanged on the accepting edge.
REQ-020 ROT_LEFT step: q[0] <= q[WIDTH-1], q[i] <= q[i-1] for i = 1..WIDTH-1.
REQ-021 ROT_RIGHT step: q[WIDTH-1] <= q[0], q[i] <= q[i+1] for i = 0..WIDTH-2.
REQ-022 In SHIFT with hold low: exactly one step per edge and remaining count decremented; on the edge that performs the last step, state -> DONE.
REQ-023 In SHIFT with hold high: q and remaining count SHALL be frozen; state stays SHIFT.
REQ-024 hold SHALL have no effect in IDLE or DONE.
REQ-025 DONE SHALL last exactly one cycle with done = 1, then -> IDLE; done SHALL be 0 in all other states.
REQ-026 Latency: LOAD, CLEAR and count-0 commands SHALL assert done in the cycle after acceptance; ROT with n and no hold SHALL assert done in cycle n+1 after acceptance.
REQ-027 Back-to-back: a new command SHALL NOT be accepted in the done cycle; the earliest acceptance is the following cycle.
REQ-028 The count SHALL be treated as unsigned; n = 2^CNT_W - 1 SHALL be honoured fully with no wrap of the remaining counter below 0.
REQ-029 q SHALL hold its value in IDLE indefinitely.

Reset
REQ-030 While rst is high: q = 0, state = IDLE, remaining count = 0, done = 0, busy = 0, cmd_ready = 1.
REQ-031 Reset assertion mid-SHIFT SHALL abort the command immediately with no done pulse.
REQ-032 The first command SHALL be acceptable on the first rising edge after rst deasserts.

Structure
REQ-033 Opcode encodings and FSM state encodings SHALL be constants in the shared package siso_ring_pkg.
REQ-034 The ring register SHALL be a sub-module ring_shift_core (ports clk, rst, ld, clr, en, dir, d, q); siso_ring_sequencer SHALL contain only the FSM, counter and handshake logic.

Verification
REQ-035 Reset, then LOAD 4'b0001 -> q = 0001 next cycle, done pulses once, busy high one cycle.
REQ-036 From q = 0001, ROT_LEFT cnt = 3 -> q = 0010, 0100, 1000 on successive edges; done in cycle 4 after acceptance.
REQ-037 From q = 1000, ROT_RIGHT cnt = 5 -> final q = 0100; done in cycle 6 after acceptance.
REQ-038 ROT_LEFT cnt = 6 from 0001 with hold high for 2 cycles after step 2 -> q frozen at 0100 during hold; final q = 0100 (6 mod 4 = 2 steps); done in cycle 9 after acceptance.
REQ-039 cmd_valid held high continuously with two queued commands -> cmd_ready low through SHIFT and DONE; second command accepted the cycle after done.
REQ-040 rst pulsed during SHIFT of a cnt = 10 rotate -> q = 0000, no done pulse, IDLE, cmd_ready = 1.

Source files
------------

// File: rtl/siso_ring_pkg.sv
// Shared constants for the ring sequencer: opcodes, FSM states, rotate direction.
package siso_ring_pkg;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'b00,
        OP_ROT_LEFT  = 2'b01,
        OP_ROT_RIGHT = 2'b10,
        OP_CLEAR     = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Rotate direction as seen by the ring core
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/ring_shift_core.sv
// Ring register: clear, parallel load, or one-position rotate per enabled edge.
// Priority is clr > ld > en. WIDTH must be at least 2.
module ring_shift_core
    import siso_ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] rot_left;
    logic [WIDTH-1:0] rot_right;

    // Per-bit wiring of the two rotated images of the register
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rot_left[gi]  = q_reg[(gi + WIDTH - 1) % WIDTH];
            assign rot_right[gi] = q_reg[(gi + 1) % WIDTH];
        end
    endgenerate

    // Register update: clear wins over load, load wins over a rotate step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (ld) begin
            q_reg <= d;
        end else if (en) begin
            q_reg <= (dir == DIR_RIGHT) ? rot_right : rot_left;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/siso_ring_sequencer.sv
// Command sequencer around a ring register: accepts LOAD / ROT_LEFT / ROT_RIGHT /
// CLEAR, runs multi-step rotates one step per cycle (pausable with hold) and
// pulses done for one cycle when each command completes.
module siso_ring_sequencer
    import siso_ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_pat,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             core_ld, core_clr, core_en;
    op_e              op;

    assign op = op_e'(cmd_op);

    // State, remaining step count and latched direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dir_reg   <= DIR_LEFT;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
        end
    end

    // Next-state, counter and ring-core control decode
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        core_ld    = 1'b0;
        core_clr   = 1'b0;
        core_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_LOAD: begin
                            core_ld    = 1'b1;
                            state_next = ST_DONE;
                        end
                        OP_CLEAR: begin
                            core_clr   = 1'b1;
                            state_next = ST_DONE;
                        end
                        OP_ROT_LEFT, OP_ROT_RIGHT: begin
                            if (cmd_cnt == '0) begin
                                state_next = ST_DONE;
                            end else begin
                                dir_next   = (op == OP_ROT_RIGHT) ? DIR_RIGHT : DIR_LEFT;
                                cnt_next   = cmd_cnt;
                                state_next = ST_SHIFT;
                            end
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_SHIFT: begin
                // Count is always >= 1 here; leaving at 1 means it never wraps below 0
                if (!hold) begin
                    core_en  = 1'b1;
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

    ring_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .ld  (core_ld),
        .clr (core_clr),
        .en  (core_en),
        .dir (dir_reg),
        .d   (cmd_pat),
        .q   (q)
    );

endmodule

// File: tb/tb_siso_ring_sequencer.sv
// Scoreboard bench for siso_ring_sequencer: the driver pushes the expected final
// ring value and done latency per command; a monitor pops on each done pulse.
module tb_siso_ring_sequencer;
    import siso_ring_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_pat = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             hold = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    siso_ring_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_pat   (cmd_pat),
        .cmd_cnt   (cmd_cnt),
        .hold      (hold),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        int               lat;
        string            name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each done pulse
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
                continue;
            end
            chk("ready_is_not_busy", int'(cmd_ready), int'(!busy));
            chk("done_single_pulse", int'(done && prev_done), 0);
            if (done) begin
                chk("sb_nonempty_on_done", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk({e.name, "_q"}, int'(q), int'(e.q));
                    chk({e.name, "_latency"}, cyc - acc_cyc, e.lat);
                    $display("txn %s: q=%b lat=%0d (expected q=%b lat=%0d)",
                             e.name, q, cyc - acc_cyc, e.q, e.lat);
                end
            end
            prev_done = done;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] pat,
                         input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] exp_q,
                         input int exp_lat, input string name, input bit push,
                         output int waits);
        exp_t e;
        bit   got;
        e.q = exp_q; e.lat = exp_lat; e.name = name;
        if (push) sb_q.push_back(e);
        cmd_op = op; cmd_pat = pat; cmd_cnt = cnt; cmd_valid = 1'b1;
        got = 1'b0;
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            waits++;
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk({name, "_accepted"}, int'(got), 1);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        chk({name, "_returns_idle"}, int'(idle), 1);
        @(posedge clk);
        #1;
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int w;
        int cnt_wait;

        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LOAD 0001 right after reset release
        issue(OP_LOAD, 4'b0001, 4'd0, 4'b0001, 1, "load_0001", 1'b1, w);
        chk("first_cmd_first_edge", w, 1);
        chk("load_busy_cycle1", int'(busy), 1);
        chk("load_done_cycle1", int'(done), 1);
        @(posedge clk);
        #1;
        chk("load_busy_cycle2", int'(busy), 0);
        chk("load_done_cycle2", int'(done), 0);

        // ROT_LEFT 3 from 0001: step-by-step values
        issue(OP_ROT_LEFT, 4'b0000, 4'd3, 4'b1000, 4, "rotl_3", 1'b1, w);
        chk("rotl_3_q_after_accept", int'(q), 4'b0001);
        @(posedge clk); #1; chk("rotl_3_step1", int'(q), 4'b0010);
        @(posedge clk); #1; chk("rotl_3_step2", int'(q), 4'b0100);
        @(posedge clk); #1; chk("rotl_3_step3", int'(q), 4'b1000);
        wait_idle("rotl_3");

        // ROT_RIGHT 5 from 1000
        issue(OP_ROT_RIGHT, 4'b0000, 4'd5, 4'b0100, 6, "rotr_5", 1'b1, w);
        wait_idle("rotr_5");

        // ROT_LEFT 6 from 0001 with hold for two edges after step 2
        issue(OP_LOAD, 4'b0001, 4'd0, 4'b0001, 1, "load_0001b", 1'b1, w);
        wait_idle("load_0001b");
        issue(OP_ROT_LEFT, 4'b0000, 4'd6, 4'b0100, 9, "rotl_6_hold", 1'b1, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_q_before", int'(q), 4'b0100);
        hold = 1'b1;
        @(posedge clk); #1; chk("hold_q_frozen1", int'(q), 4'b0100);
        @(posedge clk); #1; chk("hold_q_frozen2", int'(q), 4'b0100);
        chk("hold_busy", int'(busy), 1);
        hold = 1'b0;
        wait_idle("rotl_6_hold");

        // Count zero: immediate completion, q unchanged (hold ignored outside SHIFT)
        hold = 1'b1;
        issue(OP_ROT_RIGHT, 4'b0000, 4'd0, 4'b0100, 1, "rotr_0", 1'b1, w);
        wait_idle("rotr_0");
        hold = 1'b0;

        // Maximum count: 15 left steps from 0011 = 3 steps
        issue(OP_LOAD, 4'b0011, 4'd0, 4'b0011, 1, "load_0011", 1'b1, w);
        wait_idle("load_0011");
        issue(OP_ROT_LEFT, 4'b0000, 4'd15, 4'b1001, 16, "rotl_15", 1'b1, w);
        wait_idle("rotl_15");

        // CLEAR
        issue(OP_CLEAR, 4'b1111, 4'd7, 4'b0000, 1, "clear", 1'b1, w);
        wait_idle("clear");

        // Back-to-back with cmd_valid held high
        issue(OP_LOAD, 4'b0110, 4'd0, 4'b0110, 1, "load_0110", 1'b1, w);
        wait_idle("load_0110");
        begin
            exp_t e1, e2;
            bit   got;
            e1.q = 4'b1001; e1.lat = 3; e1.name = "b2b_rotr_2";
            e2.q = 4'b1010; e2.lat = 1; e2.name = "b2b_load_1010";
            sb_q.push_back(e1);
            sb_q.push_back(e2);
            cmd_op = OP_ROT_RIGHT; cmd_pat = 4'b0000; cmd_cnt = 4'd2; cmd_valid = 1'b1;
            @(negedge clk);
            chk("b2b_first_ready", int'(cmd_ready), 1);
            @(posedge clk); #1;
            cmd_op = OP_LOAD; cmd_pat = 4'b1010; cmd_cnt = 4'd0;
            got = 1'b0;
            cnt_wait = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                cnt_wait++;
                if (cmd_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("b2b_second_seen", int'(got), 1);
            chk("b2b_second_accept_cycle", cnt_wait, 4);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        wait_idle("b2b");

        // Reset in the middle of a 10-step rotate
        issue(OP_LOAD, 4'b0011, 4'd0, 4'b0011, 1, "load_0011b", 1'b1, w);
        wait_idle("load_0011b");
        issue(OP_ROT_LEFT, 4'b0000, 4'd10, 4'b0000, 0, "rotl_10_abort", 1'b0, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_before", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_q", int'(q), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(OP_LOAD, 4'b0101, 4'd0, 4'b0101, 1, "load_after_reset", 1'b1, w);
        chk("post_reset_first_edge", w, 1);
        wait_idle("load_after_reset");

        // Idle hold of q
        repeat (5) @(posedge clk);
        #1;
        chk("idle_q_held", int'(q), 4'b0101);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
